// File: rtl/router_pkg.sv
// Shared types and flit helpers for the NoC packet generator.
package router_pkg;

    // Destination sequencing policy; code 3 is reserved and behaves as FIXED.
    typedef enum logic [1:0] {
        GEN_FIXED  = 2'd0,
        GEN_INCR   = 2'd1,
        GEN_RANDOM = 2'd2,
        GEN_RSVD   = 2'd3
    } GEN_MODE_t;

    typedef enum logic [1:0] {
        NONE_FLIT = 2'd0,
        HEAD_FLIT = 2'd1,
        BODY_FLIT = 2'd2,
        TAIL_FLIT = 2'd3
    } flit_type_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HEAD = 3'd1,
        S_BODY = 3'd2,
        S_TAIL = 3'd3,
        S_GAP  = 3'd4
    } gen_state_t;

    typedef struct packed {
        flit_type_t  flit_type;
        logic [7:0]  xaddr;
        logic [7:0]  yaddr;
        logic [31:0] data;
        logic [31:0] reserved;
    } FLIT_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic FLIT_t make_head(input logic [7:0] x, input logic [7:0] y);
        FLIT_t f;
        f           = '0;
        f.flit_type = HEAD_FLIT;
        f.xaddr     = x;
        f.yaddr     = y;
        return f;
    endfunction

    // Body payload carries the packet number and the flit index within the packet.
    function automatic FLIT_t make_body(input logic [7:0] pkt, input logic [7:0] k);
        FLIT_t f;
        f           = '0;
        f.flit_type = BODY_FLIT;
        f.data      = {16'h0000, pkt, k};
        return f;
    endfunction

    function automatic FLIT_t make_tail(input logic [15:0] pkt);
        FLIT_t f;
        f           = '0;
        f.flit_type = TAIL_FLIT;
        f.reserved  = {16'h0000, pkt};
        return f;
    endfunction

endpackage

// File: rtl/tg_lfsr16.sv
// 16-bit Fibonacci LFSR used to pick random destinations.
module tg_lfsr16
    import router_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_step,
    output logic [15:0] o_value
);

    logic [15:0] r_value;

    // Advance one position per step request; only a reset reloads the seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= SEED;
        end else if (i_step) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/noc_pkt_gen.sv
// NoC traffic generator: emits head/body/tail packets with programmable
// destination policy, packet count and inter-packet gap.
module noc_pkt_gen
    import router_pkg::*;
#(
    parameter int          MAX_BODY  = 8,
    parameter int          X_DIM     = 4,
    parameter int          Y_DIM     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic [1:0]                     i_mode,
    input  logic [7:0]                     i_dest_x,
    input  logic [7:0]                     i_dest_y,
    input  logic [$clog2(MAX_BODY+1)-1:0]  i_body_len,
    input  logic [15:0]                    i_num_pkts,
    input  logic [7:0]                     i_gap,
    output FLIT_t                          o_flit,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_busy,
    output logic [15:0]                    o_pkt_count,
    output logic                           o_done
);

    localparam int         LEN_W  = $clog2(MAX_BODY + 1);
    localparam logic [7:0] X_MASK = 8'(X_DIM - 1);
    localparam logic [7:0] Y_MASK = 8'(Y_DIM - 1);

    gen_state_t   r_state;
    GEN_MODE_t    r_mode;
    logic [7:0]   r_dest_x;
    logic [7:0]   r_dest_y;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_k;
    logic [15:0]  r_num;
    logic [7:0]   r_gap;
    logic [7:0]   r_gap_cnt;
    logic         r_stop_pend;

    logic [15:0]  w_lfsr;
    logic [15:0]  w_lfsr_nxt;
    logic         w_xfer;
    logic         w_lfsr_step;
    logic         w_stop;
    logic         w_last;
    GEN_MODE_t    w_start_mode;
    logic [LEN_W-1:0] w_start_len;
    logic [7:0]   w_start_x;
    logic [7:0]   w_start_y;
    logic [7:0]   w_adv_x;
    logic [7:0]   w_adv_y;

    tg_lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_step  (w_lfsr_step),
        .o_value (w_lfsr)
    );

    assign w_lfsr_nxt   = lfsr_next(w_lfsr);
    assign w_xfer       = o_valid & i_ready;
    assign w_lfsr_step  = (r_state == S_TAIL) & w_xfer & (r_mode == GEN_RANDOM);
    assign w_stop       = r_stop_pend | i_stop;
    assign w_last       = ((r_num != 16'd0) && ((o_pkt_count + 16'd1) == r_num)) || w_stop;
    assign w_start_mode = GEN_MODE_t'(i_mode);
    assign w_start_len  = (i_body_len > LEN_W'(MAX_BODY)) ? LEN_W'(MAX_BODY) : i_body_len;
    assign w_start_x    = (w_start_mode == GEN_RANDOM) ? (w_lfsr[7:0] & X_MASK)  : i_dest_x;
    assign w_start_y    = (w_start_mode == GEN_RANDOM) ? (w_lfsr[15:8] & Y_MASK) : i_dest_y;

    // Destination for the packet after the current one; in RANDOM mode it is
    // taken from the LFSR value that the tail handshake is about to load.
    always_comb begin
        w_adv_x = r_dest_x;
        w_adv_y = r_dest_y;
        case (r_mode)
            GEN_INCR: begin
                if (r_dest_x == X_MASK) begin
                    w_adv_x = 8'd0;
                    w_adv_y = (r_dest_y + 8'd1) & Y_MASK;
                end else begin
                    w_adv_x = r_dest_x + 8'd1;
                end
            end
            GEN_RANDOM: begin
                w_adv_x = w_lfsr_nxt[7:0]  & X_MASK;
                w_adv_y = w_lfsr_nxt[15:8] & Y_MASK;
            end
            default: ;
        endcase
    end

    // Packet sequencer with registered flit, valid, busy, count and done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_mode      <= GEN_FIXED;
            r_dest_x    <= 8'd0;
            r_dest_y    <= 8'd0;
            r_len       <= '0;
            r_k         <= '0;
            r_num       <= 16'd0;
            r_gap       <= 8'd0;
            r_gap_cnt   <= 8'd0;
            r_stop_pend <= 1'b0;
            o_flit      <= '0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_pkt_count <= 16'd0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if ((r_state != S_IDLE) && i_stop) begin
                r_stop_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode      <= w_start_mode;
                        r_dest_x    <= w_start_x;
                        r_dest_y    <= w_start_y;
                        r_len       <= w_start_len;
                        r_num       <= i_num_pkts;
                        r_gap       <= i_gap;
                        r_stop_pend <= 1'b0;
                        o_pkt_count <= 16'd0;
                        o_busy      <= 1'b1;
                        o_valid     <= 1'b1;
                        o_flit      <= make_head(w_start_x, w_start_y);
                        r_state     <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (w_xfer) begin
                        if (r_len == '0) begin
                            o_flit  <= make_tail(o_pkt_count);
                            r_state <= S_TAIL;
                        end else begin
                            r_k     <= '0;
                            o_flit  <= make_body(o_pkt_count[7:0], 8'd0);
                            r_state <= S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (w_xfer) begin
                        if ((r_k + LEN_W'(1)) == r_len) begin
                            o_flit  <= make_tail(o_pkt_count);
                            r_state <= S_TAIL;
                        end else begin
                            r_k    <= r_k + LEN_W'(1);
                            o_flit <= make_body(o_pkt_count[7:0], 8'(r_k + LEN_W'(1)));
                        end
                    end
                end
                S_TAIL: begin
                    if (w_xfer) begin
                        o_pkt_count <= o_pkt_count + 16'd1;
                        r_dest_x    <= w_adv_x;
                        r_dest_y    <= w_adv_y;
                        if (w_last) begin
                            o_valid     <= 1'b0;
                            o_flit      <= '0;
                            o_busy      <= 1'b0;
                            o_done      <= 1'b1;
                            r_stop_pend <= 1'b0;
                            r_state     <= S_IDLE;
                        end else if (r_gap == 8'd0) begin
                            o_flit  <= make_head(w_adv_x, w_adv_y);
                            r_state <= S_HEAD;
                        end else begin
                            o_valid   <= 1'b0;
                            o_flit    <= '0;
                            r_gap_cnt <= r_gap;
                            r_state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (w_stop) begin
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (r_gap_cnt == 8'd1) begin
                        o_valid <= 1'b1;
                        o_flit  <= make_head(r_dest_x, r_dest_y);
                        r_state <= S_HEAD;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_pkt_gen.sv
// Scoreboard bench for noc_pkt_gen: a packet-level model fills expected
// queues, an independent negedge monitor consumes them.
module tb_noc_pkt_gen;
    import router_pkg::*;

    localparam int          MAX_BODY = 8;
    localparam int          X_DIM    = 4;
    localparam int          Y_DIM    = 4;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          LEN_W    = $clog2(MAX_BODY + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_stop = 1'b0;
    logic [1:0]       i_mode = 2'd0;
    logic [7:0]       i_dest_x = 8'd0;
    logic [7:0]       i_dest_y = 8'd0;
    logic [LEN_W-1:0] i_body_len = '0;
    logic [15:0]      i_num_pkts = 16'd0;
    logic [7:0]       i_gap = 8'd0;
    logic             i_ready = 1'b1;
    FLIT_t            o_flit;
    logic             o_valid;
    logic             o_busy;
    logic [15:0]      o_pkt_count;
    logic             o_done;

    noc_pkt_gen #(
        .MAX_BODY   (MAX_BODY),
        .X_DIM      (X_DIM),
        .Y_DIM      (Y_DIM),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_mode      (i_mode),
        .i_dest_x    (i_dest_x),
        .i_dest_y    (i_dest_y),
        .i_body_len  (i_body_len),
        .i_num_pkts  (i_num_pkts),
        .i_gap       (i_gap),
        .o_flit      (o_flit),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_pkt_count (o_pkt_count),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    FLIT_t       exp_q[$];
    int          gap_q[$];
    int          done_q[$];
    int          done_cnt = 0;
    bit          mon_track = 0;
    int          mon_gap = 0;
    bit          prev_stall = 0;
    FLIT_t       prev_flit;
    FLIT_t       mon_e;
    logic [15:0] m_lfsr = SEED;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    // Reference model: whole-packet expectations from the run configuration.
    task automatic model_run(input int mode, input int dx, input int dy, input int len,
                             input int npk, input int gap);
        int    x, y, bl;
        FLIT_t f;
        x  = dx;
        y  = dy;
        bl = (len > MAX_BODY) ? MAX_BODY : len;
        if (mode == 2) begin
            x = int'(m_lfsr) % X_DIM;
            y = (int'(m_lfsr) / 256) % Y_DIM;
        end
        for (int p = 0; p < npk; p++) begin
            f = '0; f.flit_type = HEAD_FLIT; f.xaddr = 8'(x); f.yaddr = 8'(y);
            exp_q.push_back(f);
            for (int k = 0; k < bl; k++) begin
                f = '0; f.flit_type = BODY_FLIT; f.data = 32'((p % 256) * 256 + k);
                exp_q.push_back(f);
            end
            f = '0; f.flit_type = TAIL_FLIT; f.reserved = 32'(p % 65536);
            exp_q.push_back(f);
            if (p < npk - 1) gap_q.push_back(gap);
            if (mode == 1) begin
                if (x == X_DIM - 1) begin
                    x = 0;
                    y = (y + 1) % Y_DIM;
                end else begin
                    x = (x + 1) % 256;
                end
            end else if (mode == 2) begin
                m_lfsr = lstep(m_lfsr);
                x = int'(m_lfsr) % X_DIM;
                y = (int'(m_lfsr) / 256) % Y_DIM;
            end
        end
        done_q.push_back(npk);
    endtask

    task automatic flush_model();
        exp_q.delete();
        gap_q.delete();
        done_q.delete();
        mon_track  = 0;
        prev_stall = 0;
    endtask

    // Monitor: flit scoreboard, stall stability, gap length and done checks.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall) begin
                chk("stall_valid_hold", 64'(o_valid), 64'd1);
                chk("stall_flit_hold", 64'(o_flit != prev_flit), 64'd0);
            end
            prev_stall = o_valid & ~i_ready;
            prev_flit  = o_flit;
            if (mon_track) begin
                if (o_done) begin
                    mon_track = 0;
                end else if (!o_valid) begin
                    mon_gap++;
                end else begin
                    if (gap_q.size() == 0) chk("gap_unexpected", 64'd1, 64'd0);
                    else chk("gap_len", 64'(mon_gap), 64'(gap_q.pop_front()));
                    mon_track = 0;
                end
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", 64'(o_flit.flit_type), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("flit_type", 64'(o_flit.flit_type), 64'(mon_e.flit_type));
                    case (mon_e.flit_type)
                        HEAD_FLIT: begin
                            chk("head_x", 64'(o_flit.xaddr), 64'(mon_e.xaddr));
                            chk("head_y", 64'(o_flit.yaddr), 64'(mon_e.yaddr));
                        end
                        BODY_FLIT: chk("body_data", 64'(o_flit.data), 64'(mon_e.data));
                        TAIL_FLIT: begin
                            chk("tail_reserved", 64'(o_flit.reserved), 64'(mon_e.reserved));
                            mon_track = 1;
                            mon_gap   = 0;
                        end
                        default: ;
                    endcase
                end
            end
            if (o_done) begin
                done_cnt++;
                if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else chk("done_pkt_count", 64'(o_pkt_count), 64'(done_q.pop_front()));
                chk("done_busy", 64'(o_busy), 64'd0);
                chk("done_valid", 64'(o_valid), 64'd0);
                chk("done_flit_zero", 64'(|o_flit), 64'd0);
            end
        end
    end

    function automatic logic ready_for(input int rmode, input int cyc);
        if (rmode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        if (rmode == 2) return ($urandom % 4) != 0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        flush_model();
        m_lfsr = SEED;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One run: start pulse, per-cycle ready/stop/extra-start driving, bounded wait for done.
    task automatic run_pkt(input int mode, input int dx, input int dy, input int len,
                           input int n, input int gap, input int rmode,
                           input int stop_pkt, input bit inject);
        int d0, cyc, npk;
        bit stopped, injected;
        npk = (n == 0) ? stop_pkt : n;
        model_run(mode, dx, dy, len, npk, gap);
        d0 = done_cnt; cyc = 0; stopped = 0; injected = 0;
        @(posedge clk); #1;
        i_mode = 2'(mode); i_dest_x = 8'(dx); i_dest_y = 8'(dy);
        i_body_len = LEN_W'(len); i_num_pkts = 16'(n); i_gap = 8'(gap);
        i_start = 1'b1;
        i_ready = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("start_latency_valid", 64'(o_valid), 64'd1);
        chk("start_busy", 64'(o_busy), 64'd1);
        chk("start_count_clear", 64'(o_pkt_count), 64'd0);
        while (done_cnt == d0 && cyc < 3000) begin
            i_ready = ready_for(rmode, cyc);
            i_stop  = 1'b0;
            i_start = 1'b0;
            if (stop_pkt > 0 && !stopped && o_valid && o_flit.flit_type == BODY_FLIT &&
                o_pkt_count == 16'(stop_pkt - 1)) begin
                i_stop  = 1'b1;
                stopped = 1;
            end
            if (inject && !injected && o_busy && cyc >= 2) begin
                i_start    = 1'b1;
                i_mode     = 2'(mode + 1);
                i_dest_x   = 8'hAA;
                i_body_len = LEN_W'(3);
                i_num_pkts = 16'd9;
                i_gap      = 8'd5;
                injected   = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_stop  = 1'b0;
        i_start = 1'b0;
        i_ready = 1'b1;
        if (cyc >= 3000) chk("run_timeout", 64'd1, 64'd0);
        chk("run_flits_left", 64'(exp_q.size()), 64'd0);
        chk("done_single_cycle", 64'(o_done), 64'd0);
    endtask

    initial begin
        int c;
        do_reset();
        #1;
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_count", 64'(o_pkt_count), 64'd0);
        chk("reset_flit_zero", 64'(|o_flit), 64'd0);

        // stop in IDLE must not affect the following run
        @(posedge clk); #1 i_stop = 1'b1;
        @(posedge clk); #1 i_stop = 1'b0;

        run_pkt(0, 3, 2, 2, 1, 0, 0, 0, 0);   // FIXED basic
        run_pkt(0, 3, 2, 2, 1, 0, 1, 0, 0);   // ready 1-0-0-1
        run_pkt(1, 3, 3, 0, 3, 1, 0, 0, 0);   // INCR wrap, head+tail only
        run_pkt(0, 1, 1, 3, 0, 2, 0, 2, 0);   // unlimited, stop in 2nd body
        do_reset();
        run_pkt(2, 0, 0, 15, 4, 1, 2, 0, 0);  // RANDOM from seed, clamped body
        for (int i = 0; i < 8; i++) begin
            run_pkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 10)),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                    2, 0, (i % 2) == 1);
        end

        // Asynchronous reset in the middle of a body
        model_run(0, 1, 2, 4, 1, 0);
        @(posedge clk); #1;
        i_mode = 2'd0; i_dest_x = 8'd1; i_dest_y = 8'd2; i_body_len = LEN_W'(4);
        i_num_pkts = 16'd0; i_gap = 8'd0; i_ready = 1'b1; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        c = 0;
        while (!(o_valid && o_flit.flit_type == BODY_FLIT) && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 50) chk("reset_mid_wait_timeout", 64'd1, 64'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(o_valid), 64'd0);
        chk("async_reset_busy", 64'(o_busy), 64'd0);
        chk("async_reset_flit_zero", 64'(|o_flit), 64'd0);
        flush_model();
        m_lfsr = SEED;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_pkt(0, 2, 1, 1, 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
